// File: rtl/alu_pkg.sv
// alu_pkg: shared width constants, opcode encoding and small helpers for the
// 8-bit ALU. The optional status flags of the ALU are enabled with the
// ALU_FLAGS_EN macro.
package alu_pkg;

    localparam int ALU_W   = 8;
    localparam int SHAMT_W = 3;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_NOT = 3'b111
    } alu_op_e;

    // True when every bit of the value is clear.
    function automatic logic is_zero(input logic [ALU_W-1:0] value);
        return (value == {ALU_W{1'b0}});
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational 8-bit logical barrel shifter. dir = 0 shifts
// left, dir = 1 shifts right; vacated bits are zero filled. With ALU_FLAGS_EN
// defined it also reports the last bit shifted out (0 for a zero shift).
module alu_shifter
    import alu_pkg::*;
(
    input  logic               dir,
    input  logic [SHAMT_W-1:0] amount,
    input  logic [ALU_W-1:0]   data_in,
    output logic [ALU_W-1:0]   data_out
`ifdef ALU_FLAGS_EN
    ,
    output logic               shift_out
`endif
);

    // Shift the operand in the requested direction.
    always_comb begin
        data_out = {ALU_W{1'b0}};
        if (dir) begin
            data_out = data_in >> amount;
        end else begin
            data_out = data_in << amount;
        end
    end

`ifdef ALU_FLAGS_EN
    logic [ALU_W:0] left_ext_s;
    logic [ALU_W:0] right_ext_s;

    // One guard bit beyond the shifted edge catches the last bit pushed out.
    always_comb begin
        left_ext_s  = {1'b0, data_in} << amount;
        right_ext_s = {data_in, 1'b0} >> amount;
        shift_out   = 1'b0;
        if (dir) begin
            shift_out = right_ext_s[0];
        end else begin
            shift_out = left_ext_s[ALU_W];
        end
    end
`endif

endmodule

// File: rtl/alu.sv
// alu: 8-bit arithmetic/logic unit with registered result and zero flag,
// one cycle latency, synchronous active-high reset.
// Optional macro ALU_FLAGS_EN adds registered carry and negative outputs.
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [ALU_W-1:0] input1,
    input  logic [ALU_W-1:0] input2,
    input  logic [2:0]       op,
    output logic [ALU_W-1:0] result,
    output logic             zero
`ifdef ALU_FLAGS_EN
    ,
    output logic             carry,
    output logic             negative
`endif
);

    alu_op_e          op_s;
    logic             shift_dir_s;
    logic [ALU_W-1:0] shift_data_s;
    logic [ALU_W-1:0] result_next_s;
    logic [ALU_W-1:0] result_r;
    logic             zero_r;

    assign op_s        = alu_op_e'(op);
    assign shift_dir_s = (op_s == OP_SHR);

`ifdef ALU_FLAGS_EN
    logic           shift_out_s;
    logic [ALU_W:0] add_full_s;
    logic           carry_next_s;
    logic           carry_r;
    logic           negative_r;
`endif

    alu_shifter u_shifter (
        .dir      (shift_dir_s),
        .amount   (input2[SHAMT_W-1:0]),
        .data_in  (input1),
        .data_out (shift_data_s)
`ifdef ALU_FLAGS_EN
        ,
        .shift_out(shift_out_s)
`endif
    );

    // Opcode decode to the next result value; unknown opcodes give zero.
    always_comb begin
        result_next_s = {ALU_W{1'b0}};
        case (op_s)
            OP_AND:  result_next_s = input1 & input2;
            OP_ADD:  result_next_s = input1 + input2;
            OP_SUB:  result_next_s = input1 - input2;
            OP_OR:   result_next_s = input1 | input2;
            OP_XOR:  result_next_s = input1 ^ input2;
            OP_SHL:  result_next_s = shift_data_s;
            OP_SHR:  result_next_s = shift_data_s;
            OP_NOT:  result_next_s = ~input1;
            default: result_next_s = {ALU_W{1'b0}};
        endcase
    end

`ifdef ALU_FLAGS_EN
    assign add_full_s = {1'b0, input1} + {1'b0, input2};

    // Carry out of ADD, borrow of SUB, shifted-out bit of shifts, else 0.
    always_comb begin
        carry_next_s = 1'b0;
        case (op_s)
            OP_ADD:  carry_next_s = add_full_s[ALU_W];
            OP_SUB:  carry_next_s = (input1 < input2);
            OP_SHL:  carry_next_s = shift_out_s;
            OP_SHR:  carry_next_s = shift_out_s;
            default: carry_next_s = 1'b0;
        endcase
    end

    // Register the extra flags alongside the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_r    <= 1'b0;
            negative_r <= 1'b0;
        end else begin
            carry_r    <= carry_next_s;
            negative_r <= result_next_s[ALU_W-1];
        end
    end

    assign carry    = carry_r;
    assign negative = negative_r;
`endif

    // Register result and its zero flag together so they never disagree.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r <= {ALU_W{1'b0}};
            zero_r   <= 1'b1;
        end else begin
            result_r <= result_next_s;
            zero_r   <= is_zero(result_next_s);
        end
    end

    assign result = result_r;
    assign zero   = zero_r;

endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu. Directed cases plus random stimulus
// compared against an arithmetic reference model.
module tb_alu;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] input1 = 8'h00;
    logic [7:0] input2 = 8'h00;
    logic [2:0] op = 3'b000;
    logic [7:0] result;
    logic       zero;
`ifdef ALU_FLAGS_EN
    logic       carry;
    logic       negative;
`endif

    int vectors = 0;
    int miscompares = 0;

    alu dut (
        .clk     (clk),
        .reset   (reset),
        .input1  (input1),
        .input2  (input2),
        .op      (op),
        .result  (result),
        .zero    (zero)
`ifdef ALU_FLAGS_EN
        ,
        .carry   (carry),
        .negative(negative)
`endif
    );

    always #5 clk = ~clk;

    // Reference result from plain integer arithmetic.
    function automatic int model_result(input int o, input int a, input int b);
        int amt;
        amt = b % 8;
        case (o)
            0: return a & b;
            1: return (a + b) % 256;
            2: return (a - b + 256) % 256;
            3: return a | b;
            4: return a ^ b;
            5: return (a * (1 << amt)) % 256;
            6: return a / (1 << amt);
            7: return 255 - a;
            default: return 0;
        endcase
    endfunction

    // Reference carry/borrow/shifted-out bit.
    function automatic int model_carry(input int o, input int a, input int b);
        int amt;
        amt = b % 8;
        case (o)
            1: return ((a + b) > 255) ? 1 : 0;
            2: return (a < b) ? 1 : 0;
            5: return (amt == 0) ? 0 : ((a * (1 << amt)) / 256) % 2;
            6: return (amt == 0) ? 0 : (a / (1 << (amt - 1))) % 2;
            default: return 0;
        endcase
    endfunction

    // Drive one set of inputs, clock once, then sample just after the edge.
    task automatic step(input logic r, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        reset  = r;
        op     = o;
        input1 = a;
        input2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        step(1'b1, 3'b001, 8'h12, 8'h34);
        step(1'b1, 3'b001, 8'h12, 8'h34);
        vectors++;
        if (result !== 8'h00 || zero !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: result=%h zero=%b, want result=00 zero=1", result, zero);
        end
`ifdef ALU_FLAGS_EN
        vectors++;
        if (carry !== 1'b0 || negative !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: carry=%b negative=%b, want 0 0", carry, negative);
        end
`endif
    endtask

    task automatic test_directed;
        logic [2:0] t_op  [12] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b110, 3'b101,
                                   3'b001, 3'b111, 3'b010, 3'b101, 3'b110, 3'b111};
        logic [7:0] t_a   [12] = '{8'h00, 8'h01, 8'h0B, 8'h05, 8'hB0, 8'h81,
                                   8'hFF, 8'h0F, 8'h00, 8'hA5, 8'hA5, 8'hFF};
        logic [7:0] t_b   [12] = '{8'h01, 8'h01, 8'h04, 8'h05, 8'h0B, 8'h01,
                                   8'h01, 8'h33, 8'h01, 8'hF8, 8'h07, 8'h00};
        logic [7:0] t_res [12] = '{8'h01, 8'h02, 8'h07, 8'h00, 8'h16, 8'h02,
                                   8'h00, 8'hF0, 8'hFF, 8'hA5, 8'h01, 8'h00};
        for (int i = 0; i < 12; i++) begin
            step(1'b0, t_op[i], t_a[i], t_b[i]);
            vectors++;
            if (result !== t_res[i] || zero !== (t_res[i] == 8'h00)) begin
                miscompares++;
                $display("FAIL directed[%0d]: result=%h zero=%b, want result=%h zero=%b",
                         i, result, zero, t_res[i], (t_res[i] == 8'h00));
            end
`ifdef ALU_FLAGS_EN
            vectors++;
            if (carry !== 1'(model_carry(int'(t_op[i]), int'(t_a[i]), int'(t_b[i])))
                || negative !== t_res[i][7]) begin
                miscompares++;
                $display("FAIL directed_flags[%0d]: carry=%b negative=%b, want carry=%0d negative=%b",
                         i, carry, negative, model_carry(int'(t_op[i]), int'(t_a[i]), int'(t_b[i])),
                         t_res[i][7]);
            end
`endif
        end
    endtask

    task automatic test_random;
        logic [2:0] o;
        logic [7:0] a;
        logic [7:0] b;
        int         exp_res;
        for (int i = 0; i < 300; i++) begin
            o = 3'($urandom_range(0, 7));
            a = 8'($urandom);
            b = 8'($urandom);
            if (i % 16 == 0) begin
                b = a;
            end else begin
                b = b;
            end
            exp_res = model_result(int'(o), int'(a), int'(b));
            step(1'b0, o, a, b);
            vectors++;
            if (result !== 8'(exp_res) || zero !== (exp_res == 0)) begin
                miscompares++;
                $display("FAIL random op=%0d a=%h b=%h: result=%h zero=%b, want result=%h zero=%b",
                         o, a, b, result, zero, 8'(exp_res), (exp_res == 0));
            end
`ifdef ALU_FLAGS_EN
            vectors++;
            if (carry !== 1'(model_carry(int'(o), int'(a), int'(b))) || negative !== (exp_res >= 128)) begin
                miscompares++;
                $display("FAIL random_flags op=%0d a=%h b=%h: carry=%b negative=%b, want carry=%0d negative=%b",
                         o, a, b, carry, negative, model_carry(int'(o), int'(a), int'(b)), (exp_res >= 128));
            end
`endif
        end
    endtask

    task automatic test_reset_midstream;
        step(1'b0, 3'b001, 8'h40, 8'h41);
        step(1'b0, 3'b001, 8'h90, 8'h11);
        vectors++;
        if (result !== 8'hA1 || zero !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_before_reset: result=%h zero=%b, want a1 0", result, zero);
        end
        step(1'b1, 3'b001, 8'h90, 8'h11);
        vectors++;
        if (result !== 8'h00 || zero !== 1'b1) begin
            miscompares++;
            $display("FAIL midstream_reset: result=%h zero=%b, want 00 1", result, zero);
        end
`ifdef ALU_FLAGS_EN
        vectors++;
        if (carry !== 1'b0 || negative !== 1'b0) begin
            miscompares++;
            $display("FAIL midstream_reset_flags: carry=%b negative=%b, want 0 0", carry, negative);
        end
`endif
        step(1'b0, 3'b001, 8'h03, 8'h04);
        vectors++;
        if (result !== 8'h07 || zero !== 1'b0) begin
            miscompares++;
            $display("FAIL after_release: result=%h zero=%b, want 07 0", result, zero);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] t_op  [3] = '{3'b000, 3'b011, 3'b100};
        logic [7:0] t_res [3] = '{8'h88, 8'hEE, 8'h66};
        for (int i = 0; i < 3; i++) begin
            step(1'b0, t_op[i], 8'hCC, 8'hAA);
            vectors++;
            if (result !== t_res[i] || zero !== 1'b0) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: result=%h zero=%b, want %h 0", i, result, zero, t_res[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_midstream();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
